// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE core's Keccak-f[1600] sequencing logic.
package shake_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PERMUTE = 2'd1,
    SQUEEZE = 2'd2
  } perm_state_t;

  localparam int unsigned KECCAK_ROUNDS = 24;
  localparam int unsigned ROUND_IDX_W   = $clog2(KECCAK_ROUNDS);

endpackage

// File: rtl/keccak_round_counter.sv
// Round-index counter for one Keccak-f permutation; advances ROUNDS_PER_CYCLE per step
// and wraps to zero after the final step.
module keccak_round_counter #(
  parameter  int unsigned NUM_ROUNDS       = 24,
  parameter  int unsigned ROUNDS_PER_CYCLE = 1,
  localparam int unsigned RW               = $clog2(NUM_ROUNDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_step,
  output logic [RW-1:0] o_count,
  output logic          o_last_step
);

  localparam logic [RW-1:0] LAST_IDX = RW'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
  localparam logic [RW-1:0] STEP     = RW'(ROUNDS_PER_CYCLE);

  logic [RW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_step) begin
      r_count <= o_last_step ? '0 : r_count + STEP;
    end
  end

  assign o_count     = r_count;
  assign o_last_step = (r_count == LAST_IDX);

endmodule

// File: rtl/keccak_perm_ctrl.sv
// Absorb/permute/squeeze sequencer for the Keccak-f[1600] state datapath.
// Datapath strobes are decoded combinationally from the state and message registers.
module keccak_perm_ctrl
  import shake_pkg::*;
#(
  parameter  int unsigned NUM_ROUNDS       = KECCAK_ROUNDS,
  parameter  int unsigned ROUNDS_PER_CYCLE = 1,
  parameter  int unsigned OUT_BLK_W        = 16,
  localparam int unsigned RW               = $clog2(NUM_ROUNDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_input_buffer_ready,
  input  logic                 i_last_block_in_buffer,
  input  logic [OUT_BLK_W-1:0] i_out_blocks,
  input  logic                 i_output_buffer_empty,
  output logic                 o_absorb_enable,
  output logic                 o_state_clear,
  output logic                 o_buffer_consumed,
  output logic                 o_round_enable,
  output logic [RW-1:0]        o_round_index,
  output logic                 o_output_buffer_wr,
  output logic                 o_busy,
  output logic                 o_done
);

  if (NUM_ROUNDS % ROUNDS_PER_CYCLE != 0) begin : g_bad_rounds_per_cycle
    $fatal(1, "keccak_perm_ctrl: ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
  end

  perm_state_t          r_state;
  perm_state_t          w_next_state;
  logic                 r_first_q;
  logic                 r_last_q;
  logic [OUT_BLK_W-1:0] r_blocks_left;

  logic                 w_absorb;
  logic                 w_state_clear;
  logic                 w_consumed;
  logic                 w_round_en;
  logic [RW-1:0]        w_round_index;
  logic                 w_wr;
  logic                 w_done;
  logic                 w_cnt_clear;
  logic                 w_cnt_step;
  logic [RW-1:0]        w_count;
  logic                 w_last_step;

  keccak_round_counter #(
    .NUM_ROUNDS      (NUM_ROUNDS),
    .ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)
  ) u_round_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_cnt_clear),
    .i_step     (w_cnt_step),
    .o_count    (w_count),
    .o_last_step(w_last_step)
  );

  // Next-state and strobe decode; strobes are forced low while reset is held.
  always_comb begin
    w_next_state  = r_state;
    w_absorb      = 1'b0;
    w_state_clear = 1'b0;
    w_consumed    = 1'b0;
    w_round_en    = 1'b0;
    w_round_index = '0;
    w_wr          = 1'b0;
    w_done        = 1'b0;
    w_cnt_clear   = 1'b0;
    w_cnt_step    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_input_buffer_ready && !rst) begin
          w_absorb      = 1'b1;
          w_state_clear = r_first_q;
          w_consumed    = 1'b1;
          w_cnt_clear   = 1'b1;
          w_next_state  = PERMUTE;
        end
      end
      PERMUTE: begin
        w_round_en    = 1'b1;
        w_round_index = w_count;
        w_cnt_step    = 1'b1;
        if (w_last_step) begin
          w_next_state = r_last_q ? SQUEEZE : IDLE;
        end
      end
      SQUEEZE: begin
        if (i_output_buffer_empty) begin
          w_wr = 1'b1;
          if (r_blocks_left == OUT_BLK_W'(1)) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = PERMUTE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State and per-message registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_first_q     <= 1'b1;
      r_last_q      <= 1'b0;
      r_blocks_left <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_absorb) begin
        r_last_q <= i_last_block_in_buffer;
        if (r_first_q) begin
          r_blocks_left <= (i_out_blocks == '0) ? OUT_BLK_W'(1) : i_out_blocks;
          r_first_q     <= 1'b0;
        end
      end
      if (w_wr) begin
        if (r_blocks_left != '0) begin
          r_blocks_left <= r_blocks_left - OUT_BLK_W'(1);
        end
        if (w_done) begin
          r_first_q <= 1'b1;
          r_last_q  <= 1'b0;
        end
      end
    end
  end

  assign o_absorb_enable    = w_absorb;
  assign o_state_clear      = w_state_clear;
  assign o_buffer_consumed  = w_consumed;
  assign o_round_enable     = w_round_en;
  assign o_round_index      = w_round_index;
  assign o_output_buffer_wr = w_wr;
  assign o_done             = w_done;
  assign o_busy             = (r_state != IDLE);

endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// Scoreboard bench for keccak_perm_ctrl: one instance with one round per cycle,
// a second with two rounds per cycle.
module tb_keccak_perm_ctrl;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ready, last, empty;
  logic [15:0] out_blocks;
  logic        absorb, sclr, consumed, rnd_en, wr, busy, done;
  logic [4:0]  rnd_idx;

  logic        ready2, last2, empty2;
  logic [15:0] out_blocks2;
  logic        absorb2, sclr2, consumed2, rnd_en2, wr2, busy2, done2;
  logic [4:0]  rnd_idx2;

  keccak_perm_ctrl #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(1), .OUT_BLK_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_input_buffer_ready(ready), .i_last_block_in_buffer(last),
    .i_out_blocks(out_blocks), .i_output_buffer_empty(empty),
    .o_absorb_enable(absorb), .o_state_clear(sclr), .o_buffer_consumed(consumed),
    .o_round_enable(rnd_en), .o_round_index(rnd_idx), .o_output_buffer_wr(wr),
    .o_busy(busy), .o_done(done)
  );

  keccak_perm_ctrl #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(2), .OUT_BLK_W(16)) u_dut2 (
    .clk(clk), .rst(rst),
    .i_input_buffer_ready(ready2), .i_last_block_in_buffer(last2),
    .i_out_blocks(out_blocks2), .i_output_buffer_empty(empty2),
    .o_absorb_enable(absorb2), .o_state_clear(sclr2), .o_buffer_consumed(consumed2),
    .o_round_enable(rnd_en2), .o_round_index(rnd_idx2), .o_output_buffer_wr(wr2),
    .o_busy(busy2), .o_done(done2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected events per instance: absorb (val=state_clear), round (val=index), write (val=done)
  ev_t exp_abs[$], exp_rnd[$], exp_wr[$];
  ev_t exp_abs2[$], exp_rnd2[$], exp_wr2[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int qsize(input bit sel, input int k);
    if (!sel) return (k == 0) ? exp_abs.size() : (k == 1) ? exp_rnd.size() : exp_wr.size();
    return (k == 0) ? exp_abs2.size() : (k == 1) ? exp_rnd2.size() : exp_wr2.size();
  endfunction

  function automatic ev_t qpop(input bit sel, input int k);
    if (!sel) return (k == 0) ? exp_abs.pop_front() : (k == 1) ? exp_rnd.pop_front() : exp_wr.pop_front();
    return (k == 0) ? exp_abs2.pop_front() : (k == 1) ? exp_rnd2.pop_front() : exp_wr2.pop_front();
  endfunction

  task automatic qpush(input bit sel, input int k, input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    if (!sel) begin
      if (k == 0) exp_abs.push_back(e); else if (k == 1) exp_rnd.push_back(e); else exp_wr.push_back(e);
    end else begin
      if (k == 0) exp_abs2.push_back(e); else if (k == 1) exp_rnd2.push_back(e); else exp_wr2.push_back(e);
    end
  endtask

  task automatic push_perm(input bit sel, input int start, input int n, input int step);
    for (int i = 0; i < n; i++) qpush(sel, 1, start + i, i * step);
  endtask

  task automatic mon(input bit sel, input logic ab, input logic cl, input logic cn,
                     input logic re, input logic [4:0] ri, input logic w, input logic dn);
    ev_t   e;
    string s = sel ? "_b" : "_a";
    if (ab) begin
      chk({"abs_pending", s}, int'(qsize(sel, 0) != 0), 1);
      chk({"abs_consumed", s}, int'(cn), 1);
      if (qsize(sel, 0) != 0) begin
        e = qpop(sel, 0);
        chk({"abs_cycle", s}, cyc, e.cyc);
        chk({"abs_state_clear", s}, int'(cl), e.val);
      end
    end
    if (cn) chk({"consumed_has_absorb", s}, int'(ab), 1);
    if (re) begin
      chk({"rnd_pending", s}, int'(qsize(sel, 1) != 0), 1);
      if (qsize(sel, 1) != 0) begin
        e = qpop(sel, 1);
        chk({"rnd_cycle", s}, cyc, e.cyc);
        chk({"rnd_index", s}, int'(ri), e.val);
      end
    end
    if (w) begin
      chk({"wr_pending", s}, int'(qsize(sel, 2) != 0), 1);
      if (qsize(sel, 2) != 0) begin
        e = qpop(sel, 2);
        chk({"wr_cycle", s}, cyc, e.cyc);
        chk({"wr_done", s}, int'(dn), e.val);
      end
    end
    if (dn) chk({"done_has_wr", s}, int'(w), 1);
  endtask

  always @(negedge clk) begin
    mon(1'b0, absorb, sclr, consumed, rnd_en, rnd_idx, wr, done);
    mon(1'b1, absorb2, sclr2, consumed2, rnd_en2, rnd_idx2, wr2, done2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_absorb"}, int'(absorb), 0);
    chk({tag, "_state_clear"}, int'(sclr), 0);
    chk({tag, "_consumed"}, int'(consumed), 0);
    chk({tag, "_round_enable"}, int'(rnd_en), 0);
    chk({tag, "_round_index"}, int'(rnd_idx), 0);
    chk({tag, "_wr"}, int'(wr), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  int t0;
  int t1;

  initial begin
    rst = 1'b1;
    ready = 1'b0; last = 1'b0; empty = 1'b0; out_blocks = 16'd0;
    ready2 = 1'b0; last2 = 1'b0; empty2 = 1'b0; out_blocks2 = 16'd0;
    #2;
    chk_quiet("reset");
    ready = 1'b1;
    #1;
    chk("reset_absorb_gated", int'(absorb), 0);
    ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single-block message, one output block
    tick(); t0 = cyc;
    ready = 1'b1; last = 1'b1; out_blocks = 16'd1; empty = 1'b1;
    qpush(0, 0, t0, 1); push_perm(0, t0 + 1, 24, 1); qpush(0, 2, t0 + 25, 1);
    tick(); ready = 1'b0;
    chk("s1_busy_running", int'(busy), 1);
    wait_until(t0 + 26);
    chk("s1_busy_after", int'(busy), 0);

    // Two-block message; B staged while A permutes
    tick(); t0 = cyc;
    ready = 1'b1; last = 1'b0; out_blocks = 16'd1;
    qpush(0, 0, t0, 1); push_perm(0, t0 + 1, 24, 1);
    tick(); ready = 1'b0;
    wait_until(t0 + 10);
    ready = 1'b1; last = 1'b1;
    qpush(0, 0, t0 + 25, 0); push_perm(0, t0 + 26, 24, 1); qpush(0, 2, t0 + 50, 1);
    wait_until(t0 + 26);
    ready = 1'b0; last = 1'b0;
    wait_until(t0 + 51);
    chk("s2_busy_after", int'(busy), 0);

    // Three output blocks with output buffer back-pressure
    tick(); t0 = cyc;
    ready = 1'b1; last = 1'b1; out_blocks = 16'd3; empty = 1'b0;
    qpush(0, 0, t0, 1); push_perm(0, t0 + 1, 24, 1);
    qpush(0, 2, t0 + 30, 0); push_perm(0, t0 + 31, 24, 1);
    qpush(0, 2, t0 + 55, 0); push_perm(0, t0 + 56, 24, 1);
    qpush(0, 2, t0 + 80, 1);
    tick(); ready = 1'b0; out_blocks = 16'd7;
    wait_until(t0 + 27);
    chk("s3_busy_stalled", int'(busy), 1);
    wait_until(t0 + 30);
    empty = 1'b1;
    wait_until(t0 + 81);
    chk("s3_busy_after", int'(busy), 0);

    // out_blocks==0 squeezes one block; next message starts fresh
    tick(); t0 = cyc;
    ready = 1'b1; last = 1'b1; out_blocks = 16'd0;
    qpush(0, 0, t0, 1); push_perm(0, t0 + 1, 24, 1); qpush(0, 2, t0 + 25, 1);
    tick(); ready = 1'b0;
    wait_until(t0 + 26);
    ready = 1'b1; last = 1'b1; out_blocks = 16'd1;
    qpush(0, 0, t0 + 26, 1); push_perm(0, t0 + 27, 24, 1); qpush(0, 2, t0 + 51, 1);
    tick(); ready = 1'b0;
    wait_until(t0 + 52);
    chk("s4_busy_after", int'(busy), 0);

    // Reset in the middle of a non-final block's permutation
    tick(); t0 = cyc;
    ready = 1'b1; last = 1'b0; out_blocks = 16'd2;
    qpush(0, 0, t0, 1); push_perm(0, t0 + 1, 12, 1);
    tick(); ready = 1'b0;
    wait_until(t0 + 12);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_quiet("midrst");
    tick(); tick();
    rst = 1'b0;
    tick(); t1 = cyc;
    ready = 1'b1; last = 1'b1; out_blocks = 16'd1;
    qpush(0, 0, t1, 1); push_perm(0, t1 + 1, 24, 1); qpush(0, 2, t1 + 25, 1);
    tick(); ready = 1'b0;
    wait_until(t1 + 26);
    chk("s5_busy_after", int'(busy), 0);

    // Two rounds per cycle
    tick(); t0 = cyc;
    ready2 = 1'b1; last2 = 1'b1; out_blocks2 = 16'd1; empty2 = 1'b1;
    qpush(1, 0, t0, 1); push_perm(1, t0 + 1, 12, 2); qpush(1, 2, t0 + 13, 1);
    tick(); ready2 = 1'b0;
    chk("s6_busy_running", int'(busy2), 1);
    wait_until(t0 + 14);
    chk("s6_busy_after", int'(busy2), 0);

    tick();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 3; k++)
        chk($sformatf("leftover_events_%0d_%0d", s, k), qsize(s[0], k), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
